// File: rtl/onehot_demux32_1to4_if.sv
// Bus bundle for the one-hot 1-to-4 router: one producer port and four lane outputs.
// ONEHOT_DEMUX_ERRCNT_EN adds the saturating illegal-select counter.
interface onehot_demux32_1to4_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [DATA_W-1:0] In_Data;
    logic [3:0]        In_Select;
    logic              In_Valid;
    logic              In_Ready;
    logic [DATA_W-1:0] Out_A;
    logic [DATA_W-1:0] Out_B;
    logic [DATA_W-1:0] Out_C;
    logic [DATA_W-1:0] Out_D;
    logic [3:0]        Out_Valid;
    logic [3:0]        Out_Ready;
    logic              Sel_Err;
`ifdef ONEHOT_DEMUX_ERRCNT_EN
    logic [7:0]        Sel_Err_Count;
`endif

    modport master (
        output In_Data, In_Select, In_Valid, Out_Ready,
        input  In_Ready, Out_A, Out_B, Out_C, Out_D, Out_Valid, Sel_Err
`ifdef ONEHOT_DEMUX_ERRCNT_EN
        , input Sel_Err_Count
`endif
    );

    modport slave (
        input  In_Data, In_Select, In_Valid, Out_Ready,
        output In_Ready, Out_A, Out_B, Out_C, Out_D, Out_Valid, Sel_Err
`ifdef ONEHOT_DEMUX_ERRCNT_EN
        , output Sel_Err_Count
`endif
    );
endinterface

// File: rtl/onehot_demux32_1to4.sv
// Registered one-hot 1-to-4 router; each lane is a one-word EMPTY/FULL buffer.
// ONEHOT_DEMUX_ERRCNT_EN enables the Sel_Err_Count output.
module onehot_demux32_1to4 #(
    parameter int unsigned DATA_W = 32
) (
    input logic                   Clk,
    input logic                   Reset_n,
    onehot_demux32_1to4_if.slave  bus
);
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 8;

    logic [LANES-1:0]  r_valid;
    logic [LANES-1:0]  w_valid_nxt;
    logic [DATA_W-1:0] r_data     [LANES];
    logic [DATA_W-1:0] w_data_nxt [LANES];
    logic              r_sel_err;
    logic              w_sel_err_nxt;
    logic              w_legal;
    logic              w_lane_free;
    logic              w_in_ready;
    logic              w_accept;
`ifdef ONEHOT_DEMUX_ERRCNT_EN
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  w_err_cnt_nxt;
`endif

    // Handshake decode: illegal selects are always accepted so they can be dropped.
    always_comb begin
        w_legal     = (bus.In_Select != '0) &&
                      ((bus.In_Select & (bus.In_Select - 4'd1)) == '0);
        w_lane_free = |(bus.In_Select & (~r_valid | bus.Out_Ready));
        w_in_ready  = Reset_n & (~w_legal | w_lane_free);
        w_accept    = bus.In_Valid & w_in_ready;
    end

    // Next-state: drains clear valid, a legal accept on the same lane overrides.
    always_comb begin
        w_valid_nxt   = r_valid & ~bus.Out_Ready;
        w_sel_err_nxt = w_accept & ~w_legal;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_data_nxt[i] = r_data[i];
            if (w_accept && w_legal && bus.In_Select[i]) begin
                w_data_nxt[i]  = bus.In_Data;
                w_valid_nxt[i] = 1'b1;
            end
        end
`ifdef ONEHOT_DEMUX_ERRCNT_EN
        w_err_cnt_nxt = r_err_cnt;
        if (w_sel_err_nxt && (r_err_cnt != {CNT_W{1'b1}})) begin
            w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_valid   <= '0;
            r_sel_err <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_data[i] <= '0;
            end
`ifdef ONEHOT_DEMUX_ERRCNT_EN
            r_err_cnt <= '0;
`endif
        end else begin
            r_valid   <= w_valid_nxt;
            r_sel_err <= w_sel_err_nxt;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
`ifdef ONEHOT_DEMUX_ERRCNT_EN
            r_err_cnt <= w_err_cnt_nxt;
`endif
        end
    end

    // Output mapping; only In_Ready is combinational.
    always_comb begin
        bus.In_Ready  = w_in_ready;
        bus.Out_Valid = r_valid;
        bus.Out_A     = r_data[0];
        bus.Out_B     = r_data[1];
        bus.Out_C     = r_data[2];
        bus.Out_D     = r_data[3];
        bus.Sel_Err   = r_sel_err;
`ifdef ONEHOT_DEMUX_ERRCNT_EN
        bus.Sel_Err_Count = r_err_cnt;
`endif
    end
endmodule

// File: tb/tb_onehot_demux32_1to4.sv
// Directed bench for onehot_demux32_1to4: reset, routing, backpressure, illegal select, mid-run reset.
// Counter checks are compiled in with ONEHOT_DEMUX_ERRCNT_EN.
module tb_onehot_demux32_1to4;
    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;

    onehot_demux32_1to4_if #(.DATA_W(32)) bus ();

    onehot_demux32_1to4 #(.DATA_W(32)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [31:0] d);
        bus.In_Valid  = v;
        bus.In_Select = sel;
        bus.In_Data   = d;
        #1;
    endtask

    logic [31:0] rt_data [4];
    logic [3:0]  rt_sel  [4];

    initial begin
        errors = 0;
        checks = 0;
        rt_data[0] = 32'h11111111; rt_sel[0] = 4'b0001;
        rt_data[1] = 32'h22222222; rt_sel[1] = 4'b0010;
        rt_data[2] = 32'h44444444; rt_sel[2] = 4'b0100;
        rt_data[3] = 32'h88888888; rt_sel[3] = 4'b1000;

        // Reset held two cycles with a valid word presented
        Reset_n       = 1'b0;
        bus.Out_Ready = 4'b0000;
        drive(1'b1, 4'b0001, 32'hDEADBEEF);
        check("rst_in_ready_comb", 32'(bus.In_Ready), 32'd0);
        step();
        step();
        check("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
        check("rst_out_a", bus.Out_A, 32'h0);
        check("rst_in_ready", 32'(bus.In_Ready), 32'd0);
        check("rst_sel_err", 32'(bus.Sel_Err), 32'd0);

        Reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.In_Ready), 32'd1);
        step();
        check("post_rst_valid", 32'(bus.Out_Valid), 32'b0001);
        check("post_rst_out_a", bus.Out_A, 32'hDEADBEEF);
        bus.Out_Ready = 4'b1111;
        drive(1'b0, 4'b0001, 32'h0);
        step();
        check("post_rst_drain", 32'(bus.Out_Valid), 32'd0);

        // Routing to each lane on consecutive cycles, consumers always ready
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rt_sel[i], rt_data[i]);
            check($sformatf("route_in_ready_%0d", i), 32'(bus.In_Ready), 32'd1);
            step();
            check($sformatf("route_valid_%0d", i), 32'(bus.Out_Valid), 32'(rt_sel[i]));
            case (i)
                0: check("route_a", bus.Out_A, 32'h11111111);
                1: check("route_b", bus.Out_B, 32'h22222222);
                2: check("route_c", bus.Out_C, 32'h44444444);
                default: check("route_d", bus.Out_D, 32'h88888888);
            endcase
        end
        drive(1'b0, 4'b0000, 32'h0);
        step();
        check("route_idle", 32'(bus.Out_Valid), 32'd0);

        // Backpressure on lane B
        bus.Out_Ready = 4'b1101;
        drive(1'b1, 4'b0010, 32'hAAAA0001);
        step();
        check("bp_b_valid", 32'(bus.Out_Valid), 32'b0010);
        check("bp_b_data1", bus.Out_B, 32'hAAAA0001);
        drive(1'b1, 4'b0010, 32'hAAAA0002);
        check("bp_in_ready_low", 32'(bus.In_Ready), 32'd0);
        step();
        check("bp_b_hold", bus.Out_B, 32'hAAAA0001);
        check("bp_b_hold_valid", 32'(bus.Out_Valid), 32'b0010);
        drive(1'b1, 4'b0100, 32'hCCCC0003);
        check("bp_c_in_ready", 32'(bus.In_Ready), 32'd1);
        step();
        check("bp_c_valid", 32'(bus.Out_Valid), 32'b0110);
        check("bp_c_data", bus.Out_C, 32'hCCCC0003);
        check("bp_b_still", bus.Out_B, 32'hAAAA0001);
        bus.Out_Ready = 4'b1111;
        drive(1'b1, 4'b0010, 32'hAAAA0002);
        check("bp_b_ready_on_drain", 32'(bus.In_Ready), 32'd1);
        step();
        check("bp_b_refill_valid", 32'(bus.Out_Valid), 32'b0010);
        check("bp_b_data2", bus.Out_B, 32'hAAAA0002);
        drive(1'b0, 4'b0000, 32'h0);
        step();
        check("bp_idle", 32'(bus.Out_Valid), 32'd0);

        // Illegal selects with lane A held full
        bus.Out_Ready = 4'b0000;
        drive(1'b1, 4'b0001, 32'h00000005);
        step();
        check("ill_a_full", 32'(bus.Out_Valid), 32'b0001);
        drive(1'b1, 4'b0000, 32'h0BADF00D);
        check("ill_zero_in_ready", 32'(bus.In_Ready), 32'd1);
        step();
        check("ill_zero_sel_err", 32'(bus.Sel_Err), 32'd1);
        check("ill_zero_valid", 32'(bus.Out_Valid), 32'b0001);
        drive(1'b1, 4'b0110, 32'h0BADF00D);
        check("ill_multi_in_ready", 32'(bus.In_Ready), 32'd1);
        step();
        check("ill_multi_sel_err", 32'(bus.Sel_Err), 32'd1);
        check("ill_multi_valid", 32'(bus.Out_Valid), 32'b0001);
        check("ill_a_unchanged", bus.Out_A, 32'h00000005);
        check("ill_b_unchanged", bus.Out_B, 32'hAAAA0002);
        drive(1'b0, 4'b0000, 32'h0);
        step();
        check("ill_idle_sel_err", 32'(bus.Sel_Err), 32'd0);
`ifdef ONEHOT_DEMUX_ERRCNT_EN
        check("ill_count", 32'(bus.Sel_Err_Count), 32'd2);
        drive(1'b1, 4'b1111, 32'h0BADF00D);
        for (int n = 0; n < 300; n++) begin
            step();
        end
        check("sat_count", 32'(bus.Sel_Err_Count), 32'hFF);
        step();
        step();
        check("sat_hold", 32'(bus.Sel_Err_Count), 32'hFF);
        check("sat_valid", 32'(bus.Out_Valid), 32'b0001);
        drive(1'b0, 4'b0000, 32'h0);
        step();
`endif

        // Reset mid-operation with lanes A and D full
        drive(1'b1, 4'b1000, 32'h0D0D0D0D);
        step();
        check("mid_ad_full", 32'(bus.Out_Valid), 32'b1001);
        check("mid_d_data", bus.Out_D, 32'h0D0D0D0D);
        drive(1'b0, 4'b0000, 32'h0);
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        check("mid_rst_valid", 32'(bus.Out_Valid), 32'd0);
        check("mid_rst_a", bus.Out_A, 32'h0);
        check("mid_rst_d", bus.Out_D, 32'h0);
`ifdef ONEHOT_DEMUX_ERRCNT_EN
        check("mid_rst_count", 32'(bus.Sel_Err_Count), 32'd0);
`endif
        bus.Out_Ready = 4'b1111;
        step();
        check("mid_no_delivery", 32'(bus.Out_Valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
